// File: rtl/icache_assoc_if.sv
// Instruction memory bus between the cache line loader and memory:
// command channel with valid/ready, response channel with valid only.
interface icache_assoc_if;
    logic        io_mem_cmd_valid;
    logic        io_mem_cmd_ready;
    logic [31:0] io_mem_cmd_payload_address;
    logic [2:0]  io_mem_cmd_payload_size;
    logic        io_mem_rsp_valid;
    logic [31:0] io_mem_rsp_payload_data;
    logic        io_mem_rsp_payload_error;

    modport master (
        output io_mem_cmd_valid,
        output io_mem_cmd_payload_address,
        output io_mem_cmd_payload_size,
        input  io_mem_cmd_ready,
        input  io_mem_rsp_valid,
        input  io_mem_rsp_payload_data,
        input  io_mem_rsp_payload_error
    );

    modport slave (
        input  io_mem_cmd_valid,
        input  io_mem_cmd_payload_address,
        input  io_mem_cmd_payload_size,
        output io_mem_cmd_ready,
        output io_mem_rsp_valid,
        output io_mem_rsp_payload_data,
        output io_mem_rsp_payload_error
    );
endinterface

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache: banked tag/data RAMs,
// round-robin refill victim and a set-by-set flush walk.
module icache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           io_flush,
    input  logic [31:0]    io_cpu_prefetch_pc,
    output logic           io_cpu_prefetch_haltIt,
    input  logic           io_cpu_fetch_isValid,
    input  logic           io_cpu_fetch_isStuck,
    input  logic [31:0]    io_cpu_fetch_physicalAddress,
    output logic [31:0]    io_cpu_fetch_data,
    input  logic           io_cpu_decode_isStuck,
    output logic [31:0]    io_cpu_decode_data,
    output logic [31:0]    io_cpu_decode_physicalAddress,
    output logic           io_cpu_decode_cacheMiss,
    output logic           io_cpu_decode_error,
    input  logic           io_cpu_fill_valid,
    input  logic [31:0]    io_cpu_fill_payload,
    icache_assoc_if.master mem
);
    localparam int WIDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WIDX_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int DIDX_W = IDX_W + WIDX_W;

    typedef enum logic [1:0] {IDLE, CMD, RSP} ld_state_e;

    ld_state_e          state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic [WIDX_W-1:0]  widx_q, widx_d;
    logic               had_err_q, had_err_d;
    logic [WAY_W-1:0]   rr_q, rr_d;
    logic               cmd_valid;
    logic               data_we;
    logic               refill_tag_we;

    logic               flush_pend_q, flush_pend_d;
    logic [IDX_W:0]     fcnt_q, fcnt_d;
    logic               fmsb_q;
    logic               flush_start;
    logic               flush_walk;

    logic [IDX_W-1:0]   tag_raddr;
    logic [DIDX_W-1:0]  data_raddr;
    logic [IDX_W-1:0]   tag_waddr;
    logic [TAG_W+1:0]   tag_wdata;
    logic [DIDX_W-1:0]  data_waddr;
    logic [IDX_W-1:0]   set_q;

    logic [WAYS-1:0]       hit;
    logic [WAYS-1:0]       way_err;
    logic [WAYS-1:0][31:0] way_data;
    logic                  fetch_err;

    logic               hit_q;
    logic               err_q;
    logic [31:0]        dec_data_q;
    logic [31:0]        dec_pa_q;

    assign set_q      = addr_q[IDX_W+OFF_W-1:OFF_W];
    assign tag_raddr  = io_cpu_prefetch_pc[IDX_W+OFF_W-1:OFF_W];
    assign data_raddr = io_cpu_prefetch_pc[IDX_W+OFF_W-1:2];
    assign data_waddr = {set_q, widx_q};

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        victim_d      = victim_q;
        widx_d        = widx_q;
        had_err_d     = had_err_q;
        cmd_valid     = 1'b0;
        data_we       = 1'b0;
        refill_tag_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (io_cpu_fill_valid) begin
                    addr_d   = io_cpu_fill_payload;
                    victim_d = rr_q;
                    state_d  = CMD;
                end
            end
            CMD: begin
                cmd_valid = 1'b1;
                if (mem.io_mem_cmd_ready) state_d = RSP;
            end
            RSP: begin
                if (mem.io_mem_rsp_valid) begin
                    data_we   = 1'b1;
                    widx_d    = widx_q + 1'b1;
                    had_err_d = had_err_q | mem.io_mem_rsp_payload_error;
                    if (widx_q == WIDX_W'(LINE_WORDS - 1)) begin
                        refill_tag_we = 1'b1;
                        had_err_d     = 1'b0;
                        widx_d        = '0;
                        state_d       = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rr_d = (WAYS > 1) ? rr_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            widx_q    <= '0;
            had_err_q <= 1'b0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            had_err_q <= had_err_d;
            if (state_q == IDLE) rr_q <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q   <= addr_d;
        victim_q <= victim_d;
    end

    assign mem.io_mem_cmd_valid           = cmd_valid;
    assign mem.io_mem_cmd_payload_address = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
    assign mem.io_mem_cmd_payload_size    = 3'(OFF_W);

    // Flush waits for an idle loader, so it never races a refill tag write.
    assign flush_start = flush_pend_q && (state_q == IDLE) && !io_cpu_fetch_isValid;
    assign flush_walk  = !fcnt_q[IDX_W];

    always_comb begin
        flush_pend_d = flush_pend_q;
        fcnt_d       = fcnt_q;
        if (flush_start) begin
            flush_pend_d = 1'b0;
            fcnt_d       = '0;
        end else if (flush_walk) begin
            fcnt_d = fcnt_q + 1'b1;
        end
        if (io_flush) flush_pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_pend_q <= 1'b1;
            fcnt_q       <= (IDX_W+1)'(SETS);
            fmsb_q       <= 1'b1;
        end else begin
            flush_pend_q <= flush_pend_d;
            fcnt_q       <= fcnt_d;
            fmsb_q       <= fcnt_q[IDX_W];
        end
    end

    assign io_cpu_prefetch_haltIt = (state_q != IDLE) || flush_pend_q ||
                                    flush_walk || (fcnt_q[IDX_W] && !fmsb_q) ||
                                    io_flush;

    assign tag_waddr = flush_walk ? fcnt_q[IDX_W-1:0] : set_q;
    assign tag_wdata = flush_walk ? '0 :
        {addr_q[31:IDX_W+OFF_W], had_err_q | mem.io_mem_rsp_payload_error, 1'b1};

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [TAG_W+1:0] tag_ram [SETS];
        logic [31:0]      data_ram [SETS*LINE_WORDS];
        logic [TAG_W+1:0] tag_rd_q;
        logic [31:0]      data_rd_q;
        logic             sel;
        logic             tag_we;

        assign sel    = (victim_q == WAY_W'(w));
        assign tag_we = flush_walk || (refill_tag_we && sel);

        always_ff @(posedge clk) begin
            if (tag_we) tag_ram[tag_waddr] <= tag_wdata;
            if (data_we && sel) data_ram[data_waddr] <= mem.io_mem_rsp_payload_data;
            if (!io_cpu_fetch_isStuck) begin
                tag_rd_q  <= tag_ram[tag_raddr];
                data_rd_q <= data_ram[data_raddr];
            end
        end

        assign hit[w] = tag_rd_q[0] &&
            (tag_rd_q[TAG_W+1:2] == io_cpu_fetch_physicalAddress[31:IDX_W+OFF_W]);
        assign way_err[w]  = tag_rd_q[1];
        assign way_data[w] = data_rd_q;
    end

    always_comb begin
        io_cpu_fetch_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            io_cpu_fetch_data = io_cpu_fetch_data | (way_data[w] & {32{hit[w]}});
        end
    end

    assign fetch_err = |(hit & way_err);

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q <= 1'b0;
            err_q <= 1'b0;
        end else if (!io_cpu_decode_isStuck) begin
            hit_q <= |hit;
            err_q <= fetch_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!io_cpu_decode_isStuck) begin
            dec_data_q <= io_cpu_fetch_data;
            dec_pa_q   <= io_cpu_fetch_physicalAddress;
        end
    end

    assign io_cpu_decode_data            = dec_data_q;
    assign io_cpu_decode_physicalAddress = dec_pa_q;
    assign io_cpu_decode_cacheMiss       = !hit_q;
    assign io_cpu_decode_error           = err_q;

    logic unused;
    assign unused = ^{io_cpu_prefetch_pc[31:IDX_W+OFF_W],
                      io_cpu_prefetch_pc[1:0], addr_q[OFF_W-1:0]};
endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised N-way set-associative instruction cache for the CPU fetch path. It replaces the single-way cache and adds configurable ways, sets and line length, with round-robin victim selection. It sits between the prefetch/fetch/decode stages and the instruction memory bus. Refill, flush-on-reset and flush-on-request behaviour is unchanged in kind; tags and data are now banked per way.

## Interface
- WAYS, 2: associativity; power of two, 1..8.
- SETS, 256: sets per way; power of two, ≥2.
- LINE_WORDS, 8: 32-bit words per line; power of two, 2..16.
- Derived: OFF_W=log2(LINE_WORDS)+2, IDX_W=log2(SETS), TAG_W=32-IDX_W-OFF_W.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- io_flush  in  1  request invalidation of whole cache.
- io_cpu_prefetch_pc  in  32  address presented one cycle before fetch.
- io_cpu_prefetch_haltIt  out  1  stall prefetch.
- io_cpu_fetch_isValid, io_cpu_fetch_isStuck  in  1  fetch stage status.
- io_cpu_fetch_physicalAddress  in  32  translated fetch address.
- io_cpu_fetch_data  out  32  hit-way word, fetch stage.
- io_cpu_decode_isStuck  in  1  decode stage hold.
- io_cpu_decode_data  out  32  registered fetch data.
- io_cpu_decode_physicalAddress  out  32  registered fetch address.
- io_cpu_decode_cacheMiss, io_cpu_decode_error  out  1  registered miss / tag error.
- io_cpu_fill_valid  in  1; io_cpu_fill_payload  in  32  start line refill at address.
- io_mem_cmd_valid  out  1; io_mem_cmd_ready  in  1; io_mem_cmd_payload_address  out  32; io_mem_cmd_payload_size  out  3.
- io_mem_rsp_valid  in  1; io_mem_rsp_payload_data  in  32; io_mem_rsp_payload_error  in  1.

## Operation
- Per way: tag RAM SETS×(TAG_W+2) holding {tag,error,valid}, and data RAM (SETS·LINE_WORDS)×32. Both are synchronous-read, read-enabled by !fetch_isStuck. Tag is indexed by prefetch_pc[IDX_W+OFF_W-1:OFF_W]; data by prefetch_pc[IDX_W+OFF_W-1:2].
- Fetch hit per way: valid && tag==physicalAddress[31:IDX_W+OFF_W].
  - fetch_data = one-hot OR-mux of hit way data; 0 if no hit.
  - error = OR of hit ways' error bits.
  - Multi-hit cannot occur by construction.
- Decode registers capture hit, error, data and physicalAddress when !decode_isStuck. cacheMiss=!hit_reg.
- Line loader states: IDLE, CMD, RSP.
  - IDLE→CMD on fill_valid: latch address; latch victim=rr counter.
  - CMD: mem_cmd_valid=1, address={addr[31:OFF_W],0}, size=OFF_W. Moves to RSP on valid&&ready.
  - RSP: each rsp_valid writes the word to victim data RAM at {set,wordIndex} and increments wordIndex (wraps at LINE_WORDS). hadError |= rsp_error.
  - On the last word: write tag {tag,hadError|rsp_error,1} to victim way, then go to IDLE. hadError and wordIndex clear.
- fill_valid while not IDLE is ignored.
- rr counter: log2(WAYS) bits; increments mod WAYS every cycle the loader is IDLE; constant 0 when WAYS=1.
- Flush: flushPending sets on reset or io_flush. It clears when pending && loader IDLE && !fetch_isValid, which also zeroes flushCounter. The counter (IDX_W+1 bits) then walks sets 0..SETS-1, writing valid=0 to all ways, until its MSB sets.
- Tag writes from flush take priority over a refill tag write in the same cycle; a refill cannot complete during a flush walk because flush waits for IDLE.

## Timing
- Reset values:
  - haltIt=1; mem_cmd_valid=0; loader IDLE.
  - flushPending=1; flushCounter MSB=1.
  - rr=0; decode hit_reg=0, so cacheMiss=1 and error=0.
  - decode_data and physicalAddress are not reset.
- Pipeline timing:
  - Prefetch pc in cycle N → fetch_data valid in cycle N+1 combinationally → decode outputs in N+2.
  - While fetch_isStuck, RAM outputs hold.
- haltIt = loader!=IDLE || flushPending || flush walk active || flushCounter MSB rose last cycle || io_flush.
- A full flush takes SETS cycles of walk plus 1 extra halted cycle.
- Refill latency from fill_valid: cmd_valid next cycle. The line is hittable the cycle after the last rsp word.
- Reset mid-refill or mid-flush: loader returns to IDLE and the flush restarts from set 0.

## Test plan
- Reset, WAYS=2 SETS=256 LINE_WORDS=8 → haltIt high for 257+ cycles; tag RAM all valid=0; cmd_valid=0.
- Miss then refill of 0x0000_1000: cmd address 0x1000, size 5; 8 rsp words 0xA0..A7 → refetch 0x1004 gives cacheMiss=0, decode_data=0xA1 two cycles after prefetch.
- Conflict: fill 0x1000, then 0x3000 (same set) with rr differing → both lines hit. A third line, 0x5000, evicts the way chosen by rr.
- Error in word 3 of refill → line tagged error; a later hit gives decode_error=1 and cacheMiss=0.
- io_flush asserted mid-refill → refill completes, then the SETS-cycle walk runs; afterwards all lookups miss.
- decode_isStuck held 3 cycles during a hit → decode outputs frozen; fill_valid during RSP is ignored (no second cmd).
